// File: rtl/bcd_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_scan_mux
//  Description : Time-multiplexed digit scanner for a common-anode multi-digit
//                7-segment display. Presents one BCD digit per scan slot to an
//                external BCD-to-7-segment decoder, drives the active-low
//                one-hot digit strobe and the decimal point, snapshots the
//                input once per frame and optionally blanks leading zeros.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    en         in   scan enable; when low the scan freezes and the display
//                    goes dark
//    digits_in  in   packed BCD, digit k = [4k+3:4k], digit 0 least significant
//    dp_mask    in   decimal point request per digit, 1 = lit
//    blank_lz   in   1 = blank leading zeros
//    bcd_out    out  BCD code for the decoder, 4'hF = blank
//    dp_out     out  decimal point for the current digit, active-high
//    digit_sel  out  active-low one-hot digit strobe
//    scan_tick  out  one-cycle pulse in the cycle after each slot advance
// ============================================================================
module bcd_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DIV_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    output logic [3:0]              bcd_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    scan_tick
);

    localparam int                IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0]  c_div_last = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  c_idx_last = IDX_W'(NUM_DIGITS - 1);
    localparam logic [3:0]        c_blank    = 4'hF;

    // State
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        idx_q,     idx_d;
    logic [4*NUM_DIGITS-1:0] snap_q,    snap_d;
    logic [NUM_DIGITS-1:0]   dp_snap_q, dp_snap_d;
    logic [3:0]              bcd_q,     bcd_d;
    logic                    dp_q,      dp_d;
    logic [NUM_DIGITS-1:0]   sel_q,     sel_d;
    logic                    tick_q,    tick_d;

    // Combinational helpers
    logic                    w_advance;
    logic                    w_wrap;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] w_src_digits;
    logic [NUM_DIGITS-1:0]   w_src_dp;
    logic [3:0]              w_digit;
    logic [NUM_DIGITS:0]     w_zero_run;

    assign w_advance = en && (div_cnt_q == c_div_last);
    assign w_wrap    = (idx_q == c_idx_last);
    assign w_idx_nxt = w_wrap ? '0 : idx_q + IDX_W'(1);

    // On the wrapping advance the new frame's digit 0 must come from the
    // incoming data, since the snapshot is only being loaded on that edge.
    assign w_src_digits = w_wrap ? digits_in : snap_q;
    assign w_src_dp     = w_wrap ? dp_mask   : dp_snap_q;
    assign w_digit      = w_src_digits[4*w_idx_nxt +: 4];

    // w_zero_run[k] = digit k and every higher digit are zero.
    assign w_zero_run[NUM_DIGITS] = 1'b1;
    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_zero_run
            assign w_zero_run[k] = (w_src_digits[4*k +: 4] == 4'd0) && w_zero_run[k+1];
        end
    endgenerate

    always_comb begin
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        dp_snap_d = dp_snap_q;
        bcd_d     = bcd_q;
        dp_d      = dp_q;
        sel_d     = sel_q;
        tick_d    = 1'b0;

        if (!en) begin
            sel_d = '1;
        end else if (w_advance) begin
            div_cnt_d = '0;
            idx_d     = w_idx_nxt;
            tick_d    = 1'b1;
            if (w_wrap) begin
                snap_d    = digits_in;
                dp_snap_d = dp_mask;
            end
            sel_d = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_idx_nxt);
            if (w_digit > 4'd9) begin
                bcd_d = c_blank;
            end else if (blank_lz && (w_idx_nxt != '0) && w_zero_run[w_idx_nxt]) begin
                bcd_d = c_blank;
            end else begin
                bcd_d = w_digit;
            end
            dp_d = w_src_dp[w_idx_nxt];
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            idx_q     <= c_idx_last;
            snap_q    <= '0;
            dp_snap_q <= '0;
            bcd_q     <= c_blank;
            dp_q      <= 1'b0;
            sel_q     <= '1;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            dp_snap_q <= dp_snap_d;
            bcd_q     <= bcd_d;
            dp_q      <= dp_d;
            sel_q     <= sel_d;
            tick_q    <= tick_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign dp_out    = dp_q;
    assign digit_sel = sel_q;
    assign scan_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_scan_mux
//  Description : Self-checking bench for bcd_scan_mux. One instance runs with
//                SCAN_DIV=4, a second with SCAN_DIV=1. Expected slot outputs
//                are queued when a frame's inputs are driven and compared as
//                each scan_tick appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_mux;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] bcd;
        logic       dp;
    } exp_t;

    logic        clk;
    logic        rst_n, rst1_n;
    logic        en, en1;
    logic [15:0] digits_in;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic [3:0]  bcd_out, bcd1;
    logic        dp_out, dp1;
    logic [3:0]  digit_sel, sel1;
    logic        scan_tick, tick1;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bcd_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_in),
        .dp_mask(dp_mask), .blank_lz(blank_lz), .bcd_out(bcd_out),
        .dp_out(dp_out), .digit_sel(digit_sel), .scan_tick(scan_tick)
    );

    bcd_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(1), .DIV_W(4)) dut1 (
        .clk(clk), .rst_n(rst1_n), .en(en1), .digits_in(digits_in),
        .dp_mask(dp_mask), .blank_lz(blank_lz), .bcd_out(bcd1),
        .dp_out(dp1), .digit_sel(sel1), .scan_tick(tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output of slot k for a frame built from d/m/blz.
    function automatic exp_t model(input logic [15:0] d, input logic [3:0] m,
                                   input logic blz, input int k);
        exp_t       e;
        logic [3:0] v;
        logic       allz;
        v    = d[4*k +: 4];
        allz = 1'b1;
        for (int j = k; j < 4; j++) if (d[4*j +: 4] != 4'd0) allz = 1'b0;
        e.sel    = 4'hF;
        e.sel[k] = 1'b0;
        if (v > 4'd9)                  e.bcd = 4'hF;
        else if (blz && k != 0 && allz) e.bcd = 4'hF;
        else                           e.bcd = v;
        e.dp = m[k];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] m, input logic blz);
        for (int k = 0; k < 4; k++) sb.push_back(model(d, m, blz, k));
    endtask

    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!scan_tick && cnt < 50);
        if (!scan_tick) check("tick_timeout", {31'd0, scan_tick}, 32'd1);
    endtask

    task automatic check_slot(input string tag, input int gap);
        int   c;
        exp_t e;
        wait_tick(c);
        check({tag, "_gap"}, c, gap);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_sel"}, {28'd0, digit_sel}, {28'd0, e.sel});
            check({tag, "_bcd"}, {28'd0, bcd_out},   {28'd0, e.bcd});
            check({tag, "_dp"},  {31'd0, dp_out},    {31'd0, e.dp});
        end
    endtask

    // Called while the scanner sits in slot 3 (or just out of reset).
    task automatic run_frame(input string tag, input logic [15:0] d,
                             input logic [3:0] m, input logic blz);
        digits_in = d;
        dp_mask   = m;
        blank_lz  = blz;
        push_frame(d, m, blz);
        for (int k = 0; k < 4; k++) check_slot($sformatf("%s_s%0d", tag, k), 4);
    endtask

    initial begin
        int   bad;
        exp_t e;
        rst_n = 1'b0; rst1_n = 1'b0;
        en = 1'b0; en1 = 1'b0;
        digits_in = 16'h1234; dp_mask = 4'b0000; blank_lz = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sel",  {28'd0, digit_sel}, 32'hF);
        check("rst_bcd",  {28'd0, bcd_out},   32'hF);
        check("rst_dp",   {31'd0, dp_out},    32'd0);
        check("rst_tick", {31'd0, scan_tick}, 32'd0);
        check("rst1_sel", {28'd0, sel1},      32'hF);

        // First frame, with a mid-frame change during slot 1
        rst_n = 1'b1; rst1_n = 1'b1; en = 1'b1;
        push_frame(16'h1234, 4'b0000, 1'b0);
        check_slot("f1_s0", 4);
        @(negedge clk);
        check("tick_one_cycle", {31'd0, scan_tick}, 32'd0);
        begin
            int c;
            wait_tick(c);
            check("f1_s1_gap", c + 1, 4);
            e = sb.pop_front();
            check("f1_s1_sel", {28'd0, digit_sel}, {28'd0, e.sel});
            check("f1_s1_bcd", {28'd0, bcd_out},   {28'd0, e.bcd});
        end
        digits_in = 16'h5678;
        check_slot("coh_s2", 4);
        check_slot("coh_s3", 4);
        run_frame("f2", 16'h5678, 4'b0000, 1'b0);

        // Leading-zero blanking
        run_frame("lz50",  16'h0050, 4'b0000, 1'b1);
        run_frame("lz00",  16'h0000, 4'b0000, 1'b1);
        run_frame("nolz",  16'h0050, 4'b0000, 1'b0);

        // Invalid code and decimal point
        run_frame("inv",   16'h00A9, 4'b0010, 1'b0);

        // Enable gating mid-slot
        digits_in = 16'h1234; dp_mask = 4'b0100; blank_lz = 1'b0;
        push_frame(16'h1234, 4'b0100, 1'b0);
        check_slot("en_s0", 4);
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_off_sel",  {28'd0, digit_sel}, 32'hF);
        check("en_off_tick", {31'd0, scan_tick}, 32'd0);
        check("en_off_bcd",  {28'd0, bcd_out},   32'h4);
        bad = 0;
        repeat (9) begin
            @(negedge clk);
            if (scan_tick || digit_sel != 4'hF || bcd_out != 4'h4) bad++;
        end
        check("en_off_hold", bad, 0);
        en = 1'b1;
        @(negedge clk);
        check("en_resume_sel", {28'd0, digit_sel}, 32'hF);
        check_slot("en_s1", 1);
        check_slot("en_s2", 4);
        check_slot("en_s3", 4);

        // Asynchronous reset between clock edges
        digits_in = 16'h4321;
        push_frame(16'h4321, 4'b0100, 1'b0);
        check_slot("ar_s0", 4);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("ar_sel",  {28'd0, digit_sel}, 32'hF);
        check("ar_bcd",  {28'd0, bcd_out},   32'hF);
        check("ar_dp",   {31'd0, dp_out},    32'd0);
        check("ar_tick", {31'd0, scan_tick}, 32'd0);
        #1 rst_n = 1'b1;
        sb.delete();
        digits_in = 16'h8765; dp_mask = 4'b1000;
        push_frame(16'h8765, 4'b1000, 1'b0);
        for (int k = 0; k < 4; k++) check_slot($sformatf("ar2_s%0d", k), 4);

        // SCAN_DIV=1: one advance per enabled cycle
        digits_in = 16'h4321; dp_mask = 4'b1001; blank_lz = 1'b0;
        push_frame(16'h4321, 4'b1001, 1'b0);
        push_frame(16'h4321, 4'b1001, 1'b0);
        en1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("d1_tick%0d", i), {31'd0, tick1}, 32'd1);
            check($sformatf("d1_sel%0d", i),  {28'd0, sel1},  {28'd0, e.sel});
            check($sformatf("d1_bcd%0d", i),  {28'd0, bcd1},  {28'd0, e.bcd});
            check($sformatf("d1_dp%0d", i),   {31'd0, dp1},   {31'd0, e.dp});
        end
        en1 = 1'b0;
        @(negedge clk);
        check("d1_off_sel",  {28'd0, sel1},  32'hF);
        check("d1_off_tick", {31'd0, tick1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
